// File: rtl/cpu4_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : cpu4_regfile_mp
// Description : Multi-port integer register file with fixed-priority writes,
//               optional write-to-read bypass and per-register busy bits.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu4_regfile_mp #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int REG_NUM     = 32,
    parameter int NRD         = 2,
    parameter int NWR         = 2,
    parameter int ZERO_REG    = 1,
    parameter int BYPASS      = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NRD*RFIDX_WIDTH-1:0]  rs_idx,
    output logic [NRD*XLEN-1:0]         rs_data,
    output logic [NRD-1:0]              rs_busy,
    input  logic [NWR-1:0]              wr_en,
    input  logic [NWR*RFIDX_WIDTH-1:0]  wr_idx,
    input  logic [NWR*XLEN-1:0]         wr_data,
    input  logic                        sb_set,
    input  logic [RFIDX_WIDTH-1:0]      sb_idx,
    output logic [REG_NUM-1:0]          busy_vec
);

    logic [XLEN-1:0] w_regs [REG_NUM];

    // One storage slot per architectural register; each decodes its own write.
    for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg
        localparam logic [RFIDX_WIDTH-1:0] c_idx      = RFIDX_WIDTH'(gi);
        localparam bit                     c_writable = !((ZERO_REG != 0) && (gi == 0));

        logic [XLEN-1:0] r_q;
        logic            r_busy;
        logic            w_we;
        logic [XLEN-1:0] w_wd;
        logic            w_set;

        // Later ports overwrite earlier matches, giving the higher port priority.
        always_comb begin
            w_we = 1'b0;
            w_wd = '0;
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && (wr_idx[p*RFIDX_WIDTH +: RFIDX_WIDTH] == c_idx)) begin
                    w_we = c_writable;
                    w_wd = wr_data[p*XLEN +: XLEN];
                end
            end
        end

        assign w_set = sb_set && (sb_idx == c_idx) && c_writable;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_q    <= '0;
                r_busy <= 1'b0;
            end else begin
                if (w_we) begin
                    r_q <= w_wd;
                end
                // A new issue outranks the writeback of an older producer.
                if (w_set) begin
                    r_busy <= 1'b1;
                end else if (w_we) begin
                    r_busy <= 1'b0;
                end
            end
        end

        assign w_regs[gi]   = r_q;
        assign busy_vec[gi] = r_busy;
    end

    for (genvar gk = 0; gk < NRD; gk++) begin : g_rd
        logic [RFIDX_WIDTH-1:0] w_idx;
        logic [XLEN-1:0]        w_data;
        logic                   w_busy;
        logic                   w_hit;

        assign w_idx = rs_idx[gk*RFIDX_WIDTH +: RFIDX_WIDTH];

        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            w_hit  = 1'b0;
            for (int j = 0; j < REG_NUM; j++) begin
                if (w_idx == RFIDX_WIDTH'(j)) begin
                    w_data = w_regs[j];
                    w_busy = busy_vec[j];
                    w_hit  = 1'b1;
                end
            end
            if (BYPASS != 0) begin
                for (int p = 0; p < NWR; p++) begin
                    if (w_hit && wr_en[p] && (wr_idx[p*RFIDX_WIDTH +: RFIDX_WIDTH] == w_idx)) begin
                        w_data = wr_data[p*XLEN +: XLEN];
                    end
                end
            end
            // Hardwired zero also masks any bypassed write aimed at x0.
            if ((ZERO_REG != 0) && (w_idx == '0)) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rs_data[gk*XLEN +: XLEN] = w_data;
        assign rs_busy[gk]              = w_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu4_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu4_regfile_mp
// Description : Scoreboard bench for two register-file configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu4_regfile_mp;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int NRD  = 2;
    localparam int NWR  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRD*RW-1:0]    rs_idx;
    logic [NWR-1:0]       wr_en;
    logic [NWR*RW-1:0]    wr_idx;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 sb_set;
    logic [RW-1:0]        sb_idx;

    logic [NRD*XLEN-1:0]  rs_data_a, rs_data_b;
    logic [NRD-1:0]       rs_busy_a, rs_busy_b;
    logic [31:0]          busy_vec_a;
    logic [15:0]          busy_vec_b;

    always #5 clk = ~clk;

    // Default configuration: 32 regs, x0 hardwired, bypass on.
    cpu4_regfile_mp #(
        .XLEN(XLEN), .RFIDX_WIDTH(RW), .REG_NUM(32), .NRD(NRD), .NWR(NWR),
        .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .rs_idx(rs_idx), .rs_data(rs_data_a), .rs_busy(rs_busy_a),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .sb_set(sb_set), .sb_idx(sb_idx), .busy_vec(busy_vec_a)
    );

    // Alternate configuration: 16 regs behind a 5-bit index, x0 ordinary, no bypass.
    cpu4_regfile_mp #(
        .XLEN(XLEN), .RFIDX_WIDTH(RW), .REG_NUM(16), .NRD(NRD), .NWR(NWR),
        .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst(rst), .rs_idx(rs_idx), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .sb_set(sb_set), .sb_idx(sb_idx), .busy_vec(busy_vec_b)
    );

    // Reference model: plain arrays holding architectural state per configuration.
    int          cfg_regs [2] = '{32, 16};
    int          cfg_zero [2] = '{1, 0};
    int          cfg_byp  [2] = '{1, 0};
    logic [31:0] m_reg  [2][32];
    bit          m_busy [2][32];

    typedef struct {
        logic [63:0] data [2];
        logic [1:0]  rb   [2];
        logic [31:0] bv   [2];
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    function automatic bit readable(int d, int idx);
        return (idx < cfg_regs[d]) && !(cfg_zero[d] != 0 && idx == 0);
    endfunction

    function automatic logic [31:0] exp_data(int d, int idx);
        logic [31:0] v;
        if (!readable(d, idx)) return 32'h0;
        v = m_reg[d][idx];
        if (cfg_byp[d] != 0) begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && int'(wr_idx[p*RW +: RW]) == idx) v = wr_data[p*XLEN +: XLEN];
            end
        end
        return v;
    endfunction

    function automatic logic exp_busy(int d, int idx);
        if (!readable(d, idx)) return 1'b0;
        return m_busy[d][idx];
    endfunction

    function automatic logic [31:0] exp_bv(int d);
        logic [31:0] v = '0;
        for (int i = 0; i < cfg_regs[d]; i++) v[i] = m_busy[d][i];
        return v;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[d][i]  = '0;
                m_busy[d][i] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        int wi;
        int si;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NWR; p++) begin
                wi = int'(wr_idx[p*RW +: RW]);
                if (wr_en[p] && readable(d, wi)) begin
                    m_reg[d][wi]  = wr_data[p*XLEN +: XLEN];
                    m_busy[d][wi] = 1'b0;
                end
            end
            si = int'(sb_idx);
            if (sb_set && readable(d, si)) m_busy[d][si] = 1'b1;
        end
    endtask

    // Inputs are already applied (just after a rising edge); record what the
    // outputs must show this cycle, then advance the model across the next edge.
    task automatic step();
        exp_t e;
        if (!rst) model_clear();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NRD; k++) begin
                e.data[d][k*32 +: 32] = exp_data(d, int'(rs_idx[k*RW +: RW]));
                e.rb[d][k]            = exp_busy(d, int'(rs_idx[k*RW +: RW]));
            end
            e.bv[d] = exp_bv(d);
        end
        e.cyc = cyc;
        q.push_back(e);
        if (rst) model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic r, input logic [1:0] we,
                         input int wi0, input logic [31:0] wd0,
                         input int wi1, input logic [31:0] wd1,
                         input logic ss, input int si, input int ri0, input int ri1);
        rst     = r;
        wr_en   = we;
        wr_idx  = {RW'(wi1), RW'(wi0)};
        wr_data = {wd1, wd0};
        sb_set  = ss;
        sb_idx  = RW'(si);
        rs_idx  = {RW'(ri1), RW'(ri0)};
        step();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp, input int c);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, c, act, exp);
        end
    endtask

    // Monitor: the DUT presents fresh outputs every cycle; sample mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("a_rs_data",  rs_data_a,          e.data[0], e.cyc);
                check("a_rs_busy",  {62'b0, rs_busy_a}, {62'b0, e.rb[0]}, e.cyc);
                check("a_busy_vec", {32'b0, busy_vec_a}, {32'b0, e.bv[0]}, e.cyc);
                check("b_rs_data",  rs_data_b,          e.data[1], e.cyc);
                check("b_rs_busy",  {62'b0, rs_busy_b}, {62'b0, e.rb[1]}, e.cyc);
                check("b_busy_vec", {48'b0, busy_vec_b}, {32'b0, e.bv[1]}, e.cyc);
            end
        end
    end

    function automatic int pick_idx();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 4));
        return int'($urandom_range(0, 31));
    endfunction

    initial begin
        int a0, a1;
        model_clear();
        rst = 1'b1; wr_en = '0; wr_idx = '0; wr_data = '0;
        sb_set = 1'b0; sb_idx = '0; rs_idx = '0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 3);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 3);
        // x5 written and marked busy, then reset asserted without a clock edge
        drive(1, 2'b01, 5, 32'hDEADBEEF, 0, 0, 1, 5, 5, 5);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5);
        // basic write with same-cycle read
        drive(1, 2'b01, 3, 32'h12345678, 0, 0, 0, 0, 3, 3);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3);
        // write collision on x7
        drive(1, 2'b11, 7, 32'h1111, 7, 32'h2222, 0, 0, 7, 3);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 7, 7);
        // zero register
        drive(1, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 7);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        // scoreboard set, clear, and set+clear together
        drive(1, 2'b00, 0, 0, 0, 0, 1, 9, 9, 0);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9);
        drive(1, 2'b10, 0, 0, 9, 32'hA5A5A5A5, 0, 0, 9, 0);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9);
        drive(1, 2'b01, 9, 32'h5A5A5A5A, 0, 0, 1, 9, 9, 9);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9);
        // index 20 lies beyond the 16-entry file
        drive(1, 2'b01, 20, 32'hCAFEF00D, 0, 0, 1, 20, 20, 4);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 20, 4);

        for (int n = 0; n < 400; n++) begin
            a0 = pick_idx();
            a1 = ($urandom_range(0, 3) == 0) ? a0 : pick_idx();
            drive(($urandom_range(0, 59) != 0), 2'($urandom_range(0, 3)),
                  a0, $urandom, a1, $urandom,
                  1'($urandom_range(0, 1)), pick_idx(),
                  ($urandom_range(0, 1) == 0) ? a0 : pick_idx(),
                  ($urandom_range(0, 1) == 0) ? a1 : pick_idx());
        end

        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit reached", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cpu4_regfile_mp.md
Name: cpu4_regfile_mp

Overview:
- Parametrised multi-port integer register file with an integrated scoreboard.
- Replaces the single-write, 2-read register file in the decode/writeback path.
- Adds N read ports, M write ports with fixed priority, optional same-cycle write-to-read bypass, and per-register busy bits for issue-stage hazard detection.
- Sits between decode (reads, busy lookup, busy set on issue) and writeback (writes, busy clear).

Parameters:
- XLEN, 32, data width of each register.
- RFIDX_WIDTH, 5, register index width.
- REG_NUM, 32, number of architectural registers (≤ 2**RFIDX_WIDTH).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy.
- BYPASS, 1, 1 = read data forwards same-cycle write data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rs_idx  in  NRD*RFIDX_WIDTH  read indices; port k is bits [k*RFIDX_WIDTH +: RFIDX_WIDTH].
- rs_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]; combinational.
- rs_busy  out  NRD  busy bit of the register addressed by port k; combinational.
- wr_en  in  NWR  write enable per write port.
- wr_idx  in  NWR*RFIDX_WIDTH  write indices.
- wr_data  in  NWR*XLEN  write data.
- sb_set  in  1  issue: mark sb_idx busy.
- sb_idx  in  RFIDX_WIDTH  destination register of issuing instruction.
- busy_vec  out  REG_NUM  registered busy bits, bit i = register i.

Behaviour:
- Reset (rst low, asynchronous): all registers = 0; all busy bits = 0. Hence rs_data = 0, rs_busy = 0, busy_vec = 0 while in reset and immediately after. Deassertion takes effect at the next rising edge.
- Write: on a rising edge, register i loads wr_data[p] for the highest-numbered p with wr_en[p] & wr_idx[p]==i.
  - Two ports writing the same register in one cycle: the higher port wins.
  - Registers not addressed hold their value.
- Write to idx ≥ REG_NUM: ignored. Read of idx ≥ REG_NUM: rs_data = 0, rs_busy = 0.
- ZERO_REG=1: writes to register 0 are ignored. Reads of register 0 return 0 and rs_busy = 0, including under bypass. sb_set to register 0 is ignored; busy_vec[0] stays 0.
- ZERO_REG=0: register 0 behaves as any other register.
- Read, BYPASS=0: rs_data = current stored value, 0-cycle combinational. Data written at an edge is visible in the following cycle.
- Read, BYPASS=1: if any write port targets rs_idx[k] this cycle with wr_en set (and the target is a writable register), rs_data[k] = that write's data. The highest-numbered matching port wins, matching write priority. Otherwise rs_data[k] = the stored value.
- Scoreboard, per register i each edge:
  - Set if sb_set & sb_idx==i.
  - Else cleared if any wr_en[p] & wr_idx[p]==i.
  - Else hold.
  - Set and clear in the same cycle leave busy = 1 (newer issue wins over older writeback).
- rs_busy[k] = busy_vec[rs_idx[k]] (registered value, no bypass of set/clear). With BYPASS=1 the issue stage ORs nothing extra; bypassed data combined with rs_busy=1 means the write completes this cycle, and the consumer may use the bypassed value.
- No handshake back-pressure: every write and set is accepted unconditionally.

Test Plan:
- Reset: assert rst=0 mid-run after writing x5=0xDEADBEEF and setting busy on x5 → rs_data=0, busy_vec=0 immediately without a clock edge; values stay 0 after release.
- Basic write/read: wr_en[0]=1, idx 3, data 0x12345678 → with BYPASS=0, read of x3 returns 0 in the same cycle and 0x12345678 in the next cycle. With BYPASS=1, read returns 0x12345678 in the same cycle.
- Write collision: port0 writes x7=0x1111, port1 writes x7=0x2222 in the same cycle → x7=0x2222 after the edge; the bypassed read in that cycle is 0x2222.
- Zero register: with ZERO_REG=1, write x0=0xFFFFFFFF and sb_set x0 → reads of x0 = 0 (same and next cycle), busy_vec[0]=0. With ZERO_REG=0, the same stimulus gives x0=0xFFFFFFFF and busy_vec[0]=1.
- Scoreboard: sb_set x9 → busy_vec[9]=1 next cycle and rs_busy=1 on a port reading x9. A later write to x9 clears it. sb_set x9 and a write to x9 in the same cycle → x9 updated, busy_vec[9] stays 1.
- Out-of-range access: with REG_NUM=16 and RFIDX_WIDTH=5, write idx 20 → no register changes. Read idx 20 → rs_data=0, rs_busy=0.
